sipo_deserializer: RTL
======================

# sipo_deserializer

Serial-in, parallel-out receiver that accepts the MSB-first bit stream produced by our parallel-to-serial shifter and reassembles it into WIDTH-bit words. The block counts qualified bits and aligns each word to an explicit start marker. Completed words are held in an output register behind a valid/ready handshake. Overrun and framing faults are reported as single-cycle pulses. It sits at the far end of the serial link, feeding parallel logic that may stall.

## Interface
- WIDTH, 4, word length in bits, at least 1.
- MSB_FIRST, 1, 1: first received bit lands in pout[WIDTH-1]; 0: first bit lands in pout[0].

- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  reset, asynchronous, active-high.
- sin  in  1  serial data bit.
- sen  in  1  bit qualifier; sin is sampled only on edges where sen=1.
- sync  in  1  start-of-word marker; meaningful only with sen=1; marks sin as bit 0 of a new word.
- pout  out  WIDTH  last completed word (holding register).
- pvalid  out  1  pout holds an unconsumed word.
- pready  in  1  consumer accepts pout on an edge where pvalid=1 and pready=1.
- busy  out  1  a word is partially received (state RECV).
- overrun  out  1  one-cycle pulse: completed word dropped because holding register full.
- frame_err  out  1  one-cycle pulse: sync arrived mid-word, partial word discarded.

## Operation
- State machine with two states:
  - HUNT (reset state): waits for a sync marker. Bits with sen=1, sync=0 are ignored.
  - RECV: a word is being collected.
- Bit counter is ceil(log2(WIDTH+1)) bits wide and counts accepted bits of the current word.
- HUNT to RECV: sen=1 and sync=1. The bit is stored as bit 0 and the count becomes 1.
  - If WIDTH=1, the word completes on that same edge and the state stays HUNT.
- RECV, sen=1, sync=0: the bit is shifted in and the count is incremented.
  - When the count reaches WIDTH, the word is complete and the state returns to HUNT.
- RECV, sen=1, sync=1: resync.
  - frame_err pulses.
  - The partial word is discarded.
  - This bit becomes bit 0 of a new word (count=1) and the state stays RECV.
- RECV, sen=0: no change to data, count or state.
- Word completion (the edge that accepts the WIDTH-th bit):
  - If pvalid=0, or pvalid=1 with pready=1 on that edge: pout is loaded with the new word and pvalid=1.
  - If pvalid=1 with pready=0: the new word is dropped, overrun pulses, and pout and pvalid are unchanged.
- Consume: pvalid=1 and pready=1 with no completion on the same edge clears pvalid. pout keeps its old value.
- Bit placement:
  - MSB_FIRST=1: the assembly register shifts left, new bit into the LSB. The first bit ends at WIDTH-1.
  - MSB_FIRST=0: the assembly register shifts right, new bit into the MSB. The first bit ends at 0.
- busy=1 exactly while the state is RECV.

## Timing
- Reset values:
  - pout=0, pvalid=0, busy=0, overrun=0, frame_err=0.
  - State HUNT, count 0, assembly register 0.
- rst clears all of the above immediately, without waiting for a clock edge.
  - A partial word in progress is lost.
  - A pending pout is lost.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Latency: pout and pvalid update on the same edge that accepts the last bit, with no extra cycle.
  - For a contiguous stream (sen held at 1), pvalid rises WIDTH-1 cycles after the edge that accepted the sync bit.
- overrun and frame_err are high for exactly the one cycle following the causing edge.
- pready is ignored while pvalid=0.
- Back-to-back words: a sync may arrive on the cycle right after a completion; no idle bit is required.

## Test plan
- WIDTH=4, reset then contiguous sen=1: sync with bits 1,0,1,1 -> after the 4th edge pvalid=1 and pout=4'b1011, busy returns to 0. Then pready=1 for one cycle -> pvalid=0 and pout stays 4'b1011.
- Gapped bits 0,1,1,0 with sen=0 for 3 cycles between each bit -> pout=4'b0110. busy stays 1 through the gaps. No pulses on overrun or frame_err.
- Word 1010 left unconsumed, then word 0110 -> overrun high for 1 cycle, pout=4'b1010, pvalid=1. The next pready drains pout and pvalid falls.
- Two bits received, then sync with 1,1,0,0 -> frame_err pulses once, pout=4'b1100, and no word is formed from the discarded partial.
- pvalid=1, and pready=1 on the same edge as a new completion (word 0011) -> pout=4'b0011, pvalid stays 1, no overrun.
- Bits 1,1,1,1 with sync=0 in HUNT -> ignored, pvalid stays 0. Assert rst between edges mid-word -> outputs 0 immediately. A subsequent full word is received correctly. With MSB_FIRST=0, bits 1,0,0,0 -> pout=4'b0001.

Source files
------------

// File: rtl/sipo_deserializer_if.sv
// sipo_deserializer_if: serial-in bit stream plus the parallel valid/ready word port and status flags.
interface sipo_deserializer_if #(parameter int WIDTH = 4);
    logic             sin;
    logic             sen;
    logic             sync;
    logic             pready;
    logic [WIDTH-1:0] pout;
    logic             pvalid;
    logic             busy;
    logic             overrun;
    logic             frame_err;
    modport master (output sin, sen, sync, pready, input pout, pvalid, busy, overrun, frame_err);
    modport slave  (input sin, sen, sync, pready, output pout, pvalid, busy, overrun, frame_err);
endinterface

// File: rtl/sipo_deserializer.sv
// sipo_deserializer: sync-aligned serial-to-parallel receiver with a valid/ready holding register.
module sipo_deserializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic                clk,
    input logic                rst,
    sipo_deserializer_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic {HUNT, RECV} state_t;
    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_asm;
    logic [WIDTH-1:0] r_pout;
    logic             r_pvalid;
    logic             r_busy;
    logic             r_overrun;
    logic             r_frame_err;
    logic [WIDTH-1:0] w_base;
    logic [WIDTH-1:0] w_word;
    logic [CW-1:0]    w_cnt;
    logic             w_acc;
    logic             w_resync;
    logic             w_done;
    // A sync bit always starts from an empty word, so the shift source is cleared for it.
    always_comb begin
        w_acc    = bus.sen && (bus.sync || r_state == RECV);
        w_resync = bus.sen && bus.sync && r_state == RECV;
        w_base   = bus.sync ? '0 : r_asm;
        w_word   = MSB_FIRST ? ((w_base << 1) | WIDTH'(bus.sin))
                             : ((w_base >> 1) | (WIDTH'(bus.sin) << (WIDTH - 1)));
        w_cnt    = bus.sync ? CW'(1) : r_cnt + CW'(1);
        w_done   = w_acc && w_cnt == CW'(WIDTH);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= HUNT;
            r_cnt       <= '0;
            r_asm       <= '0;
            r_pout      <= '0;
            r_pvalid    <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_overrun   <= 1'b0;
            r_frame_err <= w_resync;
            if (w_acc) begin
                r_asm   <= w_word;
                r_state <= w_done ? HUNT : RECV;
                r_busy  <= !w_done;
                r_cnt   <= w_done ? '0 : w_cnt;
            end
            if (w_done && (!r_pvalid || bus.pready)) begin
                r_pout   <= w_word;
                r_pvalid <= 1'b1;
            end else if (w_done) begin
                r_overrun <= 1'b1;
            end else if (r_pvalid && bus.pready) begin
                r_pvalid <= 1'b0;
            end
        end
    end
    assign bus.pout      = r_pout;
    assign bus.pvalid    = r_pvalid;
    assign bus.busy      = r_busy;
    assign bus.overrun   = r_overrun;
    assign bus.frame_err = r_frame_err;
endmodule
